vigna_bus_arbiter: RTL



---
 rtl/vigna_bus_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vigna_bus_arbiter.sv
// Merges the vigna core's instruction and data ports onto one valid/ready memory port.
// Round-robin on ties, grant held until completion, optional timeout answers stalled transfers.
module vigna_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_d;        // 1 when the data port received the most recent grant
    logic        r_bus_err;
    logic [31:0] r_err_addr;
    logic        w_gnt_valid;
    logic        w_abort;
    logic        w_done;
    logic        w_pick_d;

    assign w_gnt_valid = ((r_state == GNT_I) & i_valid) | ((r_state == GNT_D) & d_valid);
    assign w_done      = w_gnt_valid & (m_ready | w_abort);
    assign w_pick_d    = d_valid & (~i_valid | ~r_last_d);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_cnt <= '0;
                end else if (r_state == IDLE) begin
                    r_cnt <= '0;
                end else if (!m_ready && r_cnt != SAT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_abort = w_gnt_valid & ~m_ready & (r_cnt == LAST);
        end else begin : g_no_timeout
            assign w_abort = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_valid | d_valid) w_state_next = w_pick_d ? GNT_D : GNT_I;
            GNT_I:   if (!i_valid || w_done) w_state_next = IDLE;
            GNT_D:   if (!d_valid || w_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_wstrb = 4'b0;
        i_ready = 1'b0;
        i_rdata = 32'h0;
        d_ready = 1'b0;
        d_rdata = 32'h0;
        case (r_state)
            GNT_I: begin
                m_valid = i_valid;
                m_addr  = i_addr;
                i_ready = w_done;
                i_rdata = m_ready ? m_rdata : (w_abort ? ERR_DATA : 32'h0);
            end
            GNT_D: begin
                m_valid = d_valid;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
                d_ready = w_done;
                d_rdata = m_ready ? m_rdata : (w_abort ? ERR_DATA : 32'h0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_d   <= 1'b0;
            r_bus_err  <= 1'b0;
            r_err_addr <= 32'h0;
        end else begin
            if (r_state == IDLE && (i_valid || d_valid)) begin
                r_last_d <= w_pick_d;
            end
            r_bus_err <= w_abort;
            if (w_abort) begin
                r_err_addr <= m_addr;
            end
        end
    end

    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;

endmodule
